rps_round_controller: RTL and testbench

Sequences one rock-paper-scissors round at a time between the player switches, the computer-move source (random/markov predictor), and the score/LED/HEX display path. It detects a new round request and asks the predictor for a move, with a timeout fallback. It then judges the outcome, updates saturating scores, emits a one-cycle history write for the predictor, and holds the result for display. It sits between the top-level I/O and the predictor.

---
 rtl/rps_pkg.sv | 24 ++
 rtl/rps_judge.sv | 17 +
 rtl/rps_round_controller.sv | 156 +++++++++++++++
 tb/tb_rps_round_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors round controller:
// move encodings, round FSM states and the "who beats whom" rule.
package rps_pkg;

  localparam logic [1:0] ROCK    = 2'b00;
  localparam logic [1:0] SCISSOR = 2'b01;
  localparam logic [1:0] PAPER   = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_JUDGE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // True when move a defeats move b; invalid moves never win.
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == ROCK)    && (b == SCISSOR)) ||
           ((a == SCISSOR) && (b == PAPER))   ||
           ((a == PAPER)   && (b == ROCK));
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational outcome decode for one round: user move vs computer move.
// Exactly one flag is set for any pair of valid moves.
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] user,
  input  logic [1:0] com,
  output logic       uwin,
  output logic       cwin,
  output logic       draw
);

  assign draw = (user == com);
  assign uwin = beats(user, com);
  assign cwin = beats(com, user);

endmodule

// File: rtl/rps_round_controller.sv
// Round sequencer: detects a start edge, asks the predictor for a move
// (falling back to a free-running mod-3 counter on timeout or an invalid
// reply), judges the round, updates saturating scores, pulses a history
// write for the predictor and holds the result for display.
// Optional match limit: define RPS_MATCH_LIMIT_EN to end the match once
// either score reaches WIN_TARGET; otherwise match_over stays 0.
module rps_round_controller
  import rps_pkg::*;
#(
  parameter int WIN_TARGET   = 5,
  parameter int SCORE_W      = 8,
  parameter int PRED_TIMEOUT = 16,
  parameter int HOLD_CYCLES  = 25_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         user_move,
  input  logic [1:0]         pred_move,
  input  logic               pred_valid,
  output logic               pred_req,
  output logic               hist_we,
  output logic [3:0]         hist_combo,
  output logic [1:0]         com_move,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] com_score,
  output logic               uwin,
  output logic               cwin,
  output logic               draw,
  output logic               busy,
  output logic               match_over
);

  localparam int TW = $clog2(PRED_TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_t             state;
  logic               start_q;
  logic [1:0]         mod3;
  logic [1:0]         prev_user;
  logic [1:0]         user_latched;
  logic [TW-1:0]      wait_cnt;
  logic [HW-1:0]      hold_cnt;
  logic               j_uwin;
  logic               j_cwin;
  logic               j_draw;
  logic [SCORE_W-1:0] user_next;
  logic [SCORE_W-1:0] com_next;

  rps_judge u_judge (
    .user (user_latched),
    .com  (com_move),
    .uwin (j_uwin),
    .cwin (j_cwin),
    .draw (j_draw)
  );

  assign busy = (state != S_IDLE);

  // Post-round scores: bump the winner, sticking at the all-ones maximum.
  always_comb begin
    user_next = user_score;
    com_next  = com_score;
    if (j_uwin && (user_score != '1)) user_next = user_score + 1'b1;
    if (j_cwin && (com_score  != '1)) com_next  = com_score  + 1'b1;
  end

`ifdef RPS_MATCH_LIMIT_EN
  logic match_q;

  // Latch end-of-match on the same edge the winning score reaches the target.
  always_ff @(posedge clock) begin
    if (!reset) begin
      match_q <= 1'b0;
    end else if (state == S_JUDGE) begin
      if ((user_next >= SCORE_W'(WIN_TARGET)) || (com_next >= SCORE_W'(WIN_TARGET)))
        match_q <= 1'b1;
    end
  end

  assign match_over = match_q;
`else
  assign match_over = 1'b0;
`endif

  // Round FSM with registered outputs; the mod-3 fallback counter and the
  // start edge detector run every cycle regardless of state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      start_q      <= 1'b1;
      mod3         <= ROCK;
      prev_user    <= ROCK;
      user_latched <= ROCK;
      wait_cnt     <= '0;
      hold_cnt     <= '0;
      pred_req     <= 1'b0;
      hist_we      <= 1'b0;
      hist_combo   <= 4'b0000;
      com_move     <= 2'b00;
      user_score   <= '0;
      com_score    <= '0;
      uwin         <= 1'b0;
      cwin         <= 1'b0;
      draw         <= 1'b0;
    end else begin
      start_q <= start;
      mod3    <= (mod3 == PAPER) ? ROCK : mod3 + 2'd1;
      hist_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !start_q && (user_move != INVALID) && !match_over) begin
            user_latched <= user_move;
            wait_cnt     <= '0;
            pred_req     <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (pred_valid && (pred_move != INVALID)) begin
            com_move <= pred_move;
            pred_req <= 1'b0;
            state    <= S_JUDGE;
          end else if (pred_valid || (wait_cnt == TW'(PRED_TIMEOUT - 1))) begin
            com_move <= mod3;
            pred_req <= 1'b0;
            state    <= S_JUDGE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_JUDGE: begin
          uwin       <= j_uwin;
          cwin       <= j_cwin;
          draw       <= j_draw;
          user_score <= user_next;
          com_score  <= com_next;
          hist_we    <= 1'b1;
          hist_combo <= {prev_user, user_latched};
          prev_user  <= user_latched;
          hold_cnt   <= '0;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt != HW'(HOLD_CYCLES - 1)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else if (!start) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_round_controller.sv
// Scoreboard bench for rps_round_controller: the stimulus process pushes the
// expected round result when it commits a computer move, and a monitor pops
// and compares whenever the DUT pulses hist_we.
module tb_rps_round_controller;

  localparam int SCORE_W = 8;
  localparam int PT      = 4;
  localparam int HC      = 3;
  localparam int WIN     = 2;
  localparam int SMAX    = (1 << SCORE_W) - 1;

  localparam logic [1:0] ROCK    = 2'b00;
  localparam logic [1:0] SCISSOR = 2'b01;
  localparam logic [1:0] PAPER   = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         user_move;
  logic [1:0]         pred_move;
  logic               pred_valid;
  logic               pred_req;
  logic               hist_we;
  logic [3:0]         hist_combo;
  logic [1:0]         com_move;
  logic [SCORE_W-1:0] user_score;
  logic [SCORE_W-1:0] com_score;
  logic               uwin;
  logic               cwin;
  logic               draw;
  logic               busy;
  logic               match_over;

  typedef struct {
    logic [1:0]  com;
    logic        uw;
    logic        cw;
    logic        dr;
    logic [31:0] us;
    logic [31:0] cs;
    logic [3:0]  combo;
    logic        mo;
  } exp_t;

  exp_t sb[$];

  int         checks = 0;
  int         fails  = 0;
  logic [1:0] m3;
  logic [1:0] m_prev  = 2'b00;
  int         m_us    = 0;
  int         m_cs    = 0;
  logic       m_match = 1'b0;

  rps_round_controller #(
    .WIN_TARGET   (WIN),
    .SCORE_W      (SCORE_W),
    .PRED_TIMEOUT (PT),
    .HOLD_CYCLES  (HC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .user_move  (user_move),
    .pred_move  (pred_move),
    .pred_valid (pred_valid),
    .pred_req   (pred_req),
    .hist_we    (hist_we),
    .hist_combo (hist_combo),
    .com_move   (com_move),
    .user_score (user_score),
    .com_score  (com_score),
    .uwin       (uwin),
    .cwin       (cwin),
    .draw       (draw),
    .busy       (busy),
    .match_over (match_over)
  );

  always #5 clock = ~clock;

  // Reference mod-3 counter: free-running from reset, advancing every cycle.
  always @(posedge clock) begin
    if (!reset) m3 <= 2'b00;
    else        m3 <= (m3 == 2'b10) ? 2'b00 : m3 + 2'b01;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected outcome from the cyclic order rock->scissor->paper: the user wins
  // when the computer's move is one step ahead, loses when two steps ahead.
  task automatic push_expect(input logic [1:0] u, input logic [1:0] c);
    exp_t e;
    int   d;
    d = (int'(c) - int'(u) + 3) % 3;
    e.com = c;
    e.uw  = (d == 1);
    e.cw  = (d == 2);
    e.dr  = (d == 0);
    if (e.uw && m_us < SMAX) m_us++;
    if (e.cw && m_cs < SMAX) m_cs++;
`ifdef RPS_MATCH_LIMIT_EN
    if (m_us >= WIN || m_cs >= WIN) m_match = 1'b1;
`endif
    e.us    = m_us;
    e.cs    = m_cs;
    e.combo = {m_prev, u};
    e.mo    = m_match;
    m_prev  = u;
    sb.push_back(e);
  endtask

  // Monitor: every history-write pulse must correspond to a queued round.
  always @(negedge clock) begin
    if (reset === 1'b1 && hist_we === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_hist_we", 32'(hist_we), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("com_move",   32'(com_move),   32'(e.com));
        check_output("uwin",       32'(uwin),       32'(e.uw));
        check_output("cwin",       32'(cwin),       32'(e.cw));
        check_output("draw",       32'(draw),       32'(e.dr));
        check_output("user_score", 32'(user_score), e.us);
        check_output("com_score",  32'(com_score),  e.cs);
        check_output("hist_combo", 32'(hist_combo), 32'(e.combo));
        check_output("match_over", 32'(match_over), 32'(e.mo));
      end
    end
  end

  // mode 0: predictor answers with p; 1: predictor silent; 2: predictor answers 11
  task automatic apply_stimulus(input logic [1:0] u, input int mode, input logic [1:0] p);
    logic [1:0] fb;
    if (m_match) begin
      user_move = u;
      start = 1'b1;
      tick();
      tick();
      check_output("ignored_after_match_busy", 32'(busy), 32'd0);
      check_output("ignored_after_match_req",  32'(pred_req), 32'd0);
      start = 1'b0;
      tick();
      return;
    end
    user_move = u;
    start = 1'b1;
    tick();
    check_output("req_entry_pred_req", 32'(pred_req), 32'd1);
    check_output("req_entry_busy",     32'(busy),     32'd1);
    case (mode)
      0: begin
        pred_valid = 1'b1;
        pred_move  = p;
        push_expect(u, p);
        tick();
        pred_valid = 1'b0;
        check_output("judge_com_move", 32'(com_move), 32'(p));
        check_output("judge_pred_req", 32'(pred_req), 32'd0);
      end
      1: begin
        for (int i = 1; i <= PT; i++) begin
          check_output("timeout_pred_req", 32'(pred_req), 32'd1);
          if (i == PT) push_expect(u, m3);
          tick();
        end
        check_output("timeout_release", 32'(pred_req), 32'd0);
      end
      default: begin
        pred_valid = 1'b1;
        pred_move  = INVALID;
        fb = m3;
        push_expect(u, fb);
        tick();
        pred_valid = 1'b0;
        check_output("fallback_com_move", 32'(com_move), 32'(fb));
      end
    endcase
    start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check_output("return_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    start = 1'b1;
    user_move = ROCK;
    pred_move = ROCK;
    pred_valid = 1'b0;
    tick();
    tick();
    check_output("rst_user_score", 32'(user_score), 32'd0);
    check_output("rst_pred_req",   32'(pred_req),   32'd0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    check_output("held_start_busy",     32'(busy),       32'd0);
    check_output("held_start_pred_req", 32'(pred_req),   32'd0);
    check_output("idle_flags",          32'({uwin, cwin, draw, hist_we}), 32'd0);
    check_output("idle_scores",         32'({user_score, com_score}), 32'd0);
    check_output("idle_com_move",       32'(com_move),   32'd0);
    check_output("idle_match_over",     32'(match_over), 32'd0);
    start = 1'b0;
    pred_valid = 1'b1;
    pred_move = PAPER;
    tick();
    tick();
    pred_valid = 1'b0;
    check_output("idle_pred_valid_ignored", 32'(com_move), 32'd0);
    check_output("idle_pred_valid_busy",    32'(busy),     32'd0);

    apply_stimulus(ROCK,    0, SCISSOR);
    apply_stimulus(PAPER,   0, PAPER);
    apply_stimulus(SCISSOR, 0, ROCK);
    apply_stimulus(ROCK,    1, ROCK);
    apply_stimulus(PAPER,   2, ROCK);

    user_move = INVALID;
    start = 1'b1;
    tick();
    tick();
    check_output("invalid_user_busy",     32'(busy),     32'd0);
    check_output("invalid_user_pred_req", 32'(pred_req), 32'd0);
    start = 1'b0;
    tick();

    apply_stimulus(SCISSOR, 0, PAPER);
    apply_stimulus(PAPER,   1, ROCK);

    user_move = ROCK;
    start = 1'b1;
    tick();
    check_output("midreq_pred_req_before", 32'(pred_req), 32'd1);
    reset = 1'b0;
    tick();
    check_output("midreq_pred_req", 32'(pred_req), 32'd0);
    check_output("midreq_busy",     32'(busy),     32'd0);
    check_output("midreq_scores",   32'({user_score, com_score}), 32'd0);
    check_output("midreq_hist_we",  32'(hist_we),  32'd0);
    reset = 1'b1;
    start = 1'b0;
    m_us = 0;
    m_cs = 0;
    m_prev = 2'b00;
    m_match = 1'b0;
    tick();
    tick();

`ifdef RPS_MATCH_LIMIT_EN
    apply_stimulus(ROCK, 0, PAPER);
    apply_stimulus(ROCK, 0, PAPER);
    check_output("match_com_score",  32'(com_score),  32'd2);
    check_output("match_over_set",   32'(match_over), 32'd1);
    apply_stimulus(ROCK, 0, PAPER);
`else
    while (m_us < SMAX) apply_stimulus(ROCK, 0, SCISSOR);
    apply_stimulus(ROCK, 0, SCISSOR);
    check_output("sat_user_score", 32'(user_score), 32'(SMAX));
    check_output("sat_uwin",       32'(uwin),       32'd1);
`endif

    for (int i = 0; i < 5; i++) tick();
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
